// File: rtl/ll_pkg.sv
// Shared link-layer types: receive push-path sequencing states.
package ll_pkg;

   typedef enum logic [1:0] {
      RXP_OFFLINE,
      RXP_WAIT_STABLE,
      RXP_ONLINE,
      RXP_SUSPEND
   } rx_push_state_e;

endpackage

// File: rtl/ll_rx_push_ctrl.sv
// Receive push-path sequencer: link-up qualification, suspend handshake,
// and accepted-push statistics for the per-channel rx push gate.
module ll_rx_push_ctrl
   import ll_pkg::*;
#(
   parameter int STABLE_CYC = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk_wr,
   input  logic                 rst_wr,
   input  logic                 link_up,
   input  logic                 ovrd_req,
   output logic                 ovrd_ack,
   input  logic                 rx_i_pushbit,
   input  logic                 rxfifo_full,
   input  logic                 stat_clr,
   output logic                 rx_online,
   output logic                 rx_i_push_ovrd,
   output logic                 rx_overflow,
   output logic [CNT_WIDTH-1:0] push_cnt
);

   localparam int SW = $clog2(STABLE_CYC + 1);

   rx_push_state_e state, state_nxt;
   logic [SW-1:0]  stab_cnt, stab_cnt_nxt;
   logic           online_nxt, ovrd_nxt, ack_nxt;
   logic           acc;

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         state          <= RXP_OFFLINE;
         stab_cnt       <= '0;
         rx_online      <= 1'b0;
         rx_i_push_ovrd <= 1'b1;
         ovrd_ack       <= 1'b0;
      end else begin
         state          <= state_nxt;
         stab_cnt       <= stab_cnt_nxt;
         rx_online      <= online_nxt;
         rx_i_push_ovrd <= ovrd_nxt;
         ovrd_ack       <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      stab_cnt_nxt = stab_cnt;
      online_nxt   = 1'b0;
      ovrd_nxt     = 1'b1;
      ack_nxt      = 1'b0;

      // Link loss wins over everything, including a pending suspend.
      unique case (state)
         RXP_OFFLINE: begin
            if (link_up) begin
               state_nxt    = RXP_WAIT_STABLE;
               stab_cnt_nxt = SW'(1);
            end
         end
         RXP_WAIT_STABLE: begin
            if (!link_up)
               state_nxt = RXP_OFFLINE;
            else if (stab_cnt == SW'(STABLE_CYC))
               state_nxt = RXP_ONLINE;
            else
               stab_cnt_nxt = stab_cnt + SW'(1);
         end
         RXP_ONLINE: begin
            if (!link_up)
               state_nxt = RXP_OFFLINE;
            else if (ovrd_req)
               state_nxt = RXP_SUSPEND;
         end
         RXP_SUSPEND: begin
            if (!link_up)
               state_nxt = RXP_OFFLINE;
            else if (!ovrd_req)
               state_nxt = RXP_ONLINE;
         end
         default: state_nxt = RXP_OFFLINE;
      endcase

      if (state_nxt == RXP_OFFLINE)
         stab_cnt_nxt = '0;

      // Outputs are decoded from the next state so they change with the state register.
      unique case (state_nxt)
         RXP_ONLINE: begin
            online_nxt = 1'b1;
            ovrd_nxt   = 1'b0;
         end
         RXP_SUSPEND: begin
            online_nxt = 1'b1;
            ack_nxt    = 1'b1;
         end
         default: ;
      endcase
   end

   // Same qualification the push gate applies, so stats track real FIFO writes.
   assign acc = rx_i_pushbit & rx_online & ~rx_i_push_ovrd;

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         rx_overflow <= 1'b0;
         push_cnt    <= '0;
      end else if (stat_clr) begin
         rx_overflow <= 1'b0;
         push_cnt    <= CNT_WIDTH'(acc);
      end else begin
         rx_overflow <= rx_overflow | (acc & rxfifo_full);
         push_cnt    <= push_cnt + CNT_WIDTH'(acc);
      end
   end

endmodule

// File: tb/tb_ll_rx_push_ctrl.sv
// Directed bench for ll_rx_push_ctrl: bring-up timing, suspend handshake,
// link-loss priority and push statistics with a narrow counter.
module tb_ll_rx_push_ctrl;

   localparam int STABLE_CYC = 16;
   localparam int CNT_WIDTH  = 4;

   logic                 clk_wr = 1'b0;
   logic                 rst_wr;
   logic                 link_up;
   logic                 ovrd_req;
   logic                 ovrd_ack;
   logic                 rx_i_pushbit;
   logic                 rxfifo_full;
   logic                 stat_clr;
   logic                 rx_online;
   logic                 rx_i_push_ovrd;
   logic                 rx_overflow;
   logic [CNT_WIDTH-1:0] push_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_wr = ~clk_wr;

   ll_rx_push_ctrl #(.STABLE_CYC(STABLE_CYC), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk_wr         (clk_wr),
      .rst_wr         (rst_wr),
      .link_up        (link_up),
      .ovrd_req       (ovrd_req),
      .ovrd_ack       (ovrd_ack),
      .rx_i_pushbit   (rx_i_pushbit),
      .rxfifo_full    (rxfifo_full),
      .stat_clr       (stat_clr),
      .rx_online      (rx_online),
      .rx_i_push_ovrd (rx_i_push_ovrd),
      .rx_overflow    (rx_overflow),
      .push_cnt       (push_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_wr);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_wr = 1'b1;
      tick(2);
      rst_wr = 1'b0;
   endtask

   initial begin
      rst_wr       = 1'b1;
      link_up      = 1'b0;
      ovrd_req     = 1'b0;
      rx_i_pushbit = 1'b0;
      rxfifo_full  = 1'b0;
      stat_clr     = 1'b0;
      do_reset();

      chk("rst_online", rx_online, 0);
      chk("rst_ovrd", rx_i_push_ovrd, 1);
      chk("rst_ack", ovrd_ack, 0);
      chk("rst_ovf", rx_overflow, 0);
      chk("rst_cnt", push_cnt, 0);

      // pushes while offline are ignored even with a full FIFO
      rx_i_pushbit = 1'b1; rxfifo_full = 1'b1;
      tick(2);
      rx_i_pushbit = 1'b0; rxfifo_full = 1'b0;
      chk("offl_cnt", push_cnt, 0);
      chk("offl_ovf", rx_overflow, 0);

      // 1: bring-up, online on the 17th edge
      link_up = 1'b1;
      tick(16);
      chk("t1_pre_online", rx_online, 0);
      chk("t1_pre_ovrd", rx_i_push_ovrd, 1);
      tick();
      chk("t1_online", rx_online, 1);
      chk("t1_ovrd", rx_i_push_ovrd, 0);

      // 2: glitch restarts qualification
      do_reset();
      link_up = 1'b1;
      tick(10);
      link_up = 1'b0;
      tick();
      chk("t2_glitch_online", rx_online, 0);
      link_up = 1'b1;
      tick(16);
      chk("t2_pre_online", rx_online, 0);
      tick();
      chk("t2_online", rx_online, 1);

      // 3: suspend handshake, pushes suppressed
      ovrd_req = 1'b1;
      tick();
      chk("t3_ack", ovrd_ack, 1);
      chk("t3_ovrd", rx_i_push_ovrd, 1);
      chk("t3_online", rx_online, 1);
      rx_i_pushbit = 1'b1; rxfifo_full = 1'b1;
      tick(3);
      rx_i_pushbit = 1'b0; rxfifo_full = 1'b0;
      chk("t3_cnt", push_cnt, 0);
      chk("t3_ovf", rx_overflow, 0);
      ovrd_req = 1'b0;
      tick();
      chk("t3_ack_drop", ovrd_ack, 0);
      chk("t3_ovrd_drop", rx_i_push_ovrd, 0);

      // 4: link loss beats suspend; held request granted after return
      ovrd_req = 1'b1;
      tick();
      chk("t4_ack", ovrd_ack, 1);
      link_up = 1'b0;
      tick();
      chk("t4_off_ack", ovrd_ack, 0);
      chk("t4_off_online", rx_online, 0);
      chk("t4_off_ovrd", rx_i_push_ovrd, 1);
      link_up = 1'b1;
      tick(17);
      chk("t4_online", rx_online, 1);
      chk("t4_online_ack", ovrd_ack, 0);
      chk("t4_online_ovrd", rx_i_push_ovrd, 0);
      tick();
      chk("t4_susp_ack", ovrd_ack, 1);
      chk("t4_susp_ovrd", rx_i_push_ovrd, 1);
      ovrd_req = 1'b0;
      tick();
      chk("t4_resume", ovrd_ack, 0);

      // 5: counting and overflow
      rx_i_pushbit = 1'b1;
      tick(3);
      chk("t5_cnt3", push_cnt, 3);
      chk("t5_ovf0", rx_overflow, 0);
      rxfifo_full = 1'b1;
      tick();
      rx_i_pushbit = 1'b0; rxfifo_full = 1'b0;
      chk("t5_cnt4", push_cnt, 4);
      chk("t5_ovf1", rx_overflow, 1);
      tick(2);
      chk("t5_ovf_sticky", rx_overflow, 1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("t5_clr_cnt", push_cnt, 0);
      chk("t5_clr_ovf", rx_overflow, 0);

      // 6: 4-bit wrap and clear coincident with a push
      rx_i_pushbit = 1'b1;
      tick(17);
      chk("t6_wrap", push_cnt, 1);
      tick(4);
      chk("t6_cnt5", push_cnt, 5);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0; rx_i_pushbit = 1'b0;
      chk("t6_clr_push", push_cnt, 1);

      // reset mid-operation while online with a set overflow
      rx_i_pushbit = 1'b1; rxfifo_full = 1'b1;
      tick();
      rx_i_pushbit = 1'b0; rxfifo_full = 1'b0;
      chk("mid_ovf_set", rx_overflow, 1);
      rst_wr = 1'b1;
      tick();
      rst_wr = 1'b0;
      chk("mid_online", rx_online, 0);
      chk("mid_ovrd", rx_i_push_ovrd, 1);
      chk("mid_cnt", push_cnt, 0);
      chk("mid_ovf", rx_overflow, 0);
      // link_up still high: qualification restarts from scratch
      tick(16);
      chk("mid_pre_online", rx_online, 0);
      tick();
      chk("mid_online_again", rx_online, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
